// File: rtl/divider_seq_param_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [WIDTH_MAX-1:0] most_neg(input int width);
    logic [WIDTH_MAX-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/divider_seq_param_if.sv
// Request/result bundle of the sequential divider.
interface divider_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_seq_param_div_step.sv
// One combinational restoring-division step on WIDTH+1 bits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   partial_s;
  logic [WIDTH-1:0] diff_s;

  // Trial subtraction; the true difference is below the divisor, so the low WIDTH bits suffice.
  always_comb begin
    partial_s = {rem_in, bit_in};
    diff_s    = partial_s[WIDTH-1:0] - divisor;
    if (partial_s >= {1'b0, divisor}) begin
      q_bit   = 1'b1;
      rem_out = diff_s;
    end else begin
      q_bit   = 1'b0;
      rem_out = partial_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/divider_seq_param.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, with
// run-time signed mode, divide-by-zero and signed-overflow status.
module divider_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  divider_seq_param_if.slave  bus
);

  localparam int                    CW            = $clog2(WIDTH);
  localparam logic [WIDTH_MAX-1:0]  MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]      MOST_NEG      = MOST_NEG_FULL[WIDTH-1:0];
  localparam logic [CW-1:0]         CNT_INIT      = CW'(WIDTH - 1);

  state_t           state_r, state_nxt;
  logic [CW-1:0]    cnt_r, cnt_nxt;
  logic [WIDTH-1:0] q_shift_r, q_shift_nxt;
  logic [WIDTH-1:0] rem_r, rem_nxt;
  logic [WIDTH-1:0] dvs_r, dvs_nxt;
  logic [WIDTH-1:0] dividend_r, dividend_nxt;
  logic             neg_q_r, neg_q_nxt;
  logic             neg_rem_r, neg_rem_nxt;
  logic             ovf_pend_r, ovf_pend_nxt;
  logic [WIDTH-1:0] quotient_r, quotient_nxt;
  logic [WIDTH-1:0] remainder_r, remainder_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;
  logic             dbz_r, dbz_nxt;
  logic             ovf_r, ovf_nxt;

  logic             neg_dd_s;
  logic             neg_dv_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (q_shift_r[WIDTH-1]),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Next-state and datapath update for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    q_shift_nxt   = q_shift_r;
    rem_nxt       = rem_r;
    dvs_nxt       = dvs_r;
    dividend_nxt  = dividend_r;
    neg_q_nxt     = neg_q_r;
    neg_rem_nxt   = neg_rem_r;
    ovf_pend_nxt  = ovf_pend_r;
    quotient_nxt  = quotient_r;
    remainder_nxt = remainder_r;
    busy_nxt      = busy_r;
    done_nxt      = 1'b0;
    dbz_nxt       = dbz_r;
    ovf_nxt       = ovf_r;
    neg_dd_s      = bus.signed_mode & bus.dividend[WIDTH-1];
    neg_dv_s      = bus.signed_mode & bus.divisor[WIDTH-1];

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          dividend_nxt = bus.dividend;
          q_shift_nxt  = neg_dd_s ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
          dvs_nxt      = neg_dv_s ? ({WIDTH{1'b0}} - bus.divisor) : bus.divisor;
          rem_nxt      = {WIDTH{1'b0}};
          cnt_nxt      = CNT_INIT;
          neg_q_nxt    = neg_dd_s ^ neg_dv_s;
          neg_rem_nxt  = neg_dd_s;
          ovf_pend_nxt = bus.signed_mode & (bus.dividend == MOST_NEG) &
                         (bus.divisor == {WIDTH{1'b1}});
          busy_nxt     = 1'b1;
          ovf_nxt      = 1'b0;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            dbz_nxt   = 1'b1;
            state_nxt = FIX;
          end else begin
            dbz_nxt   = 1'b0;
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      CALC: begin
        rem_nxt     = step_rem_s;
        q_shift_nxt = {q_shift_r[WIDTH-2:0], step_q_s};
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt = FIX;
        end else begin
          cnt_nxt   = cnt_r - CW'(1);
          state_nxt = CALC;
        end
      end

      FIX: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        // The -2^(W-1)/-1 case falls out of the magnitude path wrapped; only the flag is extra.
        if (dbz_r) begin
          quotient_nxt  = {WIDTH{1'b1}};
          remainder_nxt = dividend_r;
          ovf_nxt       = 1'b0;
        end else begin
          quotient_nxt  = neg_q_r ? ({WIDTH{1'b0}} - q_shift_r) : q_shift_r;
          remainder_nxt = neg_rem_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
          ovf_nxt       = ovf_pend_r;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Operand, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      q_shift_r   <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      dividend_r  <= {WIDTH{1'b0}};
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      ovf_pend_r  <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt;
      q_shift_r   <= q_shift_nxt;
      rem_r       <= rem_nxt;
      dvs_r       <= dvs_nxt;
      dividend_r  <= dividend_nxt;
      neg_q_r     <= neg_q_nxt;
      neg_rem_r   <= neg_rem_nxt;
      ovf_pend_r  <= ovf_pend_nxt;
      quotient_r  <= quotient_nxt;
      remainder_r <= remainder_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
      dbz_r       <= dbz_nxt;
      ovf_r       <= ovf_nxt;
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;

endmodule
